// File: rtl/adc_responder_if.sv
// adc_responder_if
// Pin-level bundle between an ADC controller and the parallel ADC
// (or its emulator).
//   CONVST_18 : conversion start, rising edge starts a conversion
//   RD_18     : read strobe, active low
//   PD_18     : 0 = power down, 1 = normal operation
//   EOC_18    : end of conversion, active high
//   DB_18     : conversion result bus, 0 when not enabled
//   DB_oe     : data bus output enable
// modport master : controller side (drives CONVST/RD/PD)
// modport slave  : converter side (drives EOC/DB)
interface adc_responder_if #(
  parameter int DATA_W = 12
);
  logic              CONVST_18;
  logic              RD_18;
  logic              PD_18;
  logic              EOC_18;
  logic [DATA_W-1:0] DB_18;
  logic              DB_oe;

  modport master (
    output CONVST_18, RD_18, PD_18,
    input  EOC_18, DB_18, DB_oe
  );

  modport slave (
    input  CONVST_18, RD_18, PD_18,
    output EOC_18, DB_18, DB_oe
  );
endinterface

// File: rtl/adc_responder.sv
// adc_responder
// Behavioural-but-synthesizable stand-in for the external parallel ADC.
// Accepts conversion starts, models conversion time and power-down
// wake-up, flags end-of-conversion and returns the result under RD.
// Ports:
//   clk_100M    : system clock, all pin inputs are synchronous to it
//   Reset       : asynchronous, active-low reset
//   pins        : ADC pin bundle (slave side)
//   use_ramp    : 1 = internal ramp data, 0 = analog_code
//   analog_code : emulated analog input code
//   busy        : high while converting or waking up
//   overrun     : sticky, a start was lost or unread data was overwritten
//
// state | meaning
// IDLE  | powered, waiting for a conversion start
// CONV  | converting, counter runs down to 0
// DONE  | result latched, EOC high until read or restarted
// PWRDN | powered down (PD_18 low), result retained
// WAKE  | PD released, counter runs down to 0 before IDLE
module adc_responder #(
  parameter int DATA_W      = 12,
  parameter int CONV_CYCLES = 8,
  parameter int WAKE_CYCLES = 16,
  parameter int RAMP_STEP   = 1
) (
  input  logic              clk_100M,
  input  logic              Reset,
  adc_responder_if.slave    pins,
  input  logic              use_ramp,
  input  logic [DATA_W-1:0] analog_code,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_MAX = (CONV_CYCLES > WAKE_CYCLES) ? CONV_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_DONE,
    S_PWRDN,
    S_WAKE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic [DATA_W-1:0] db_q, db_d;
  logic              db_oe_q, db_oe_d;
  logic              overrun_q, overrun_d;
  logic              convst_q, rd_q;
  logic              convst_rise, rd_fall;

  assign convst_rise = pins.CONVST_18 & ~convst_q;
  assign rd_fall     = ~pins.RD_18 & rd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ramp_d    = ramp_q;
    overrun_d = overrun_q;

    if (!pins.PD_18) begin
      // Power-down beats every other event; result is retained.
      state_d = S_PWRDN;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (convst_rise) begin
            state_d = S_CONV;
            cnt_d   = CNT_W'(CONV_CYCLES - 1);
          end
        end
        S_CONV: begin
          if (convst_rise) overrun_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            if (use_ramp) begin
              result_d = ramp_q;
              ramp_d   = ramp_q + DATA_W'(RAMP_STEP);
            end else begin
              result_d = analog_code;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (convst_rise) begin
            // A read on the same edge counts as consuming the data.
            state_d = S_CONV;
            cnt_d   = CNT_W'(CONV_CYCLES - 1);
            if (!rd_fall) overrun_d = 1'b1;
          end else if (rd_fall) begin
            state_d = S_IDLE;
          end
        end
        S_PWRDN: begin
          state_d = S_WAKE;
          cnt_d   = CNT_W'(WAKE_CYCLES - 1);
        end
        S_WAKE: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Bus enable looks at the next state so power-down drops it immediately.
    db_oe_d = ~pins.RD_18 & (state_d != S_PWRDN);
    db_d    = db_oe_d ? result_d : '0;
  end

  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      ramp_q    <= '0;
      db_q      <= '0;
      db_oe_q   <= 1'b0;
      overrun_q <= 1'b0;
      convst_q  <= 1'b0;
      rd_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ramp_q    <= ramp_d;
      db_q      <= db_d;
      db_oe_q   <= db_oe_d;
      overrun_q <= overrun_d;
      convst_q  <= pins.CONVST_18;
      rd_q      <= pins.RD_18;
    end
  end

  assign pins.EOC_18 = (state_q == S_DONE);
  assign pins.DB_18  = db_q;
  assign pins.DB_oe  = db_oe_q;
  assign busy        = (state_q == S_CONV) || (state_q == S_WAKE);
  assign overrun     = overrun_q;

endmodule
